// File: rtl/mc_core_sequencer.sv
// Multicycle RV32I control sequencer: FETCH -> EXEC [-> MEM] -> FETCH, HALT on SYSTEM or illegal.
// State and IR are registered; control outputs decode from them so branch/ready flags act in-cycle.
module mc_core_sequencer #(
    parameter bit HALT_ON_ILLEGAL = 1'b1
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Instr,
    output logic        imem_req,
    input  logic        imem_valid,
    output logic        dmem_req,
    input  logic        dmem_ready,
    output logic        MemWrite,
    input  logic        Zero,
    input  logic        lt,
    input  logic        ltu,
    output logic [1:0]  ResultSrc,
    output logic [1:0]  PCSrc,
    output logic        ALUSrc,
    output logic        RegWrite,
    output logic [2:0]  ImmSrc,
    output logic [3:0]  ALUControl,
    output logic        PCEn,
    output logic [31:0] retire_count,
    output logic        halted,
    output logic        illegal
);

    localparam logic [6:0] OPC_OP     = 7'b0110011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_MISC   = 7'b0001111;
    localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

    localparam logic [3:0] ALU_ADD = 4'b0000, ALU_SUB = 4'b0001, ALU_AND = 4'b0010,
                           ALU_OR  = 4'b0011, ALU_XOR = 4'b0100, ALU_SLT = 4'b0101,
                           ALU_SLTU = 4'b0110, ALU_SLL = 4'b0111, ALU_SRL = 4'b1000,
                           ALU_SRA = 4'b1001, ALU_PASSB = 4'b1010;

    localparam logic [2:0] IMM_I = 3'b000, IMM_S = 3'b001, IMM_B = 3'b010,
                           IMM_J = 3'b011, IMM_U = 3'b100;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t      state;
    state_t      exec_next;
    logic [31:0] ir;
    logic [6:0]  opcode;
    logic [6:0]  funct7;
    logic [2:0]  funct3;
    logic        bad;
    logic        taken;
    logic        alt;
    logic        is_store;
    logic [3:0]  alu_op;
    logic        fields_unused;

    assign opcode        = ir[6:0];
    assign funct3        = ir[14:12];
    assign funct7        = ir[31:25];
    assign is_store      = (opcode == OPC_STORE);
    assign fields_unused = ^{ir[24:15], ir[11:7]};
    // For OP-IMM, funct7 is immediate data except on SRLI/SRAI.
    assign alt           = funct7[5] && ((opcode == OPC_OP) || (funct3 == 3'b101));

    always_comb begin
        bad = 1'b0;
        case (opcode)
            OPC_OP, OPC_LUI, OPC_JAL, OPC_LOAD, OPC_STORE, OPC_MISC, OPC_SYSTEM: bad = 1'b0;
            OPC_OPIMM:  bad = ((funct3 == 3'b001) && (funct7 != 7'b0000000)) ||
                              ((funct3 == 3'b101) && (funct7 != 7'b0000000) && (funct7 != 7'b0100000));
            OPC_JALR:   bad = (funct3 != 3'b000);
            OPC_BRANCH: bad = (funct3[2:1] == 2'b01);
            default:    bad = 1'b1;
        endcase
    end

    always_comb begin
        alu_op = ALU_ADD;
        case (funct3)
            3'b000: alu_op = alt ? ALU_SUB : ALU_ADD;
            3'b001: alu_op = ALU_SLL;
            3'b010: alu_op = ALU_SLT;
            3'b011: alu_op = ALU_SLTU;
            3'b100: alu_op = ALU_XOR;
            3'b101: alu_op = alt ? ALU_SRA : ALU_SRL;
            3'b110: alu_op = ALU_OR;
            default: alu_op = ALU_AND;
        endcase
    end

    always_comb begin
        taken = 1'b0;
        case (funct3)
            3'b000: taken = Zero;
            3'b001: taken = !Zero;
            3'b100: taken = lt;
            3'b101: taken = !lt;
            3'b110: taken = ltu;
            3'b111: taken = !ltu;
            default: taken = 1'b0;
        endcase
    end

    always_comb begin
        imem_req   = 1'b0;
        dmem_req   = 1'b0;
        MemWrite   = 1'b0;
        ResultSrc  = 2'b00;
        PCSrc      = 2'b00;
        ALUSrc     = 1'b0;
        RegWrite   = 1'b0;
        ImmSrc     = IMM_I;
        ALUControl = ALU_ADD;
        PCEn       = 1'b0;
        halted     = 1'b0;
        exec_next  = FETCH;
        unique case (state)
            // Reset parks the FSM in FETCH; gate the request so it is low while reset is held.
            FETCH: imem_req = reset;
            EXEC: begin
                if (bad) begin
                    PCEn      = !HALT_ON_ILLEGAL;
                    exec_next = HALT_ON_ILLEGAL ? HALT : FETCH;
                end else begin
                    case (opcode)
                        OPC_OP: begin
                            ALUControl = alu_op;
                            RegWrite   = 1'b1;
                            PCEn       = 1'b1;
                        end
                        OPC_OPIMM: begin
                            ALUSrc     = 1'b1;
                            ALUControl = alu_op;
                            RegWrite   = 1'b1;
                            PCEn       = 1'b1;
                        end
                        OPC_LUI: begin
                            ImmSrc     = IMM_U;
                            ALUSrc     = 1'b1;
                            ALUControl = ALU_PASSB;
                            RegWrite   = 1'b1;
                            PCEn       = 1'b1;
                        end
                        OPC_JAL: begin
                            ImmSrc    = IMM_J;
                            ResultSrc = 2'b10;
                            PCSrc     = 2'b01;
                            RegWrite  = 1'b1;
                            PCEn      = 1'b1;
                        end
                        OPC_JALR: begin
                            ALUSrc    = 1'b1;
                            ResultSrc = 2'b10;
                            PCSrc     = 2'b10;
                            RegWrite  = 1'b1;
                            PCEn      = 1'b1;
                        end
                        OPC_BRANCH: begin
                            ImmSrc     = IMM_B;
                            ALUControl = ALU_SUB;
                            PCSrc      = taken ? 2'b01 : 2'b00;
                            PCEn       = 1'b1;
                        end
                        OPC_LOAD: begin
                            ALUSrc    = 1'b1;
                            exec_next = MEM;
                        end
                        OPC_STORE: begin
                            ImmSrc    = IMM_S;
                            ALUSrc    = 1'b1;
                            exec_next = MEM;
                        end
                        OPC_MISC:   PCEn = 1'b1;
                        OPC_SYSTEM: exec_next = HALT;
                        default:    exec_next = FETCH;
                    endcase
                end
            end
            MEM: begin
                dmem_req = 1'b1;
                MemWrite = is_store;
                ImmSrc   = is_store ? IMM_S : IMM_I;
                ALUSrc   = 1'b1;
                if (dmem_ready) begin
                    PCEn = 1'b1;
                    if (!is_store) begin
                        RegWrite  = 1'b1;
                        ResultSrc = 2'b01;
                    end
                end
            end
            HALT: halted = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= FETCH;
            ir           <= '0;
            retire_count <= '0;
            illegal      <= 1'b0;
        end else begin
            if (PCEn) retire_count <= retire_count + 32'd1;
            unique case (state)
                FETCH: if (imem_valid) begin
                    ir    <= Instr;
                    state <= EXEC;
                end
                EXEC: begin
                    state <= exec_next;
                    if (bad && (exec_next == HALT)) illegal <= 1'b1;
                end
                MEM:  if (dmem_ready) state <= FETCH;
                HALT: state <= HALT;
            endcase
        end
    end

endmodule

// File: tb/tb_mc_core_sequencer.sv
// Randomized and directed bench for mc_core_sequencer against an instruction-level control model.
module tb_mc_core_sequencer;

    localparam bit HALT_P = 1'b1;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Instr = '0;
    logic        imem_valid = 1'b0;
    logic        dmem_ready = 1'b0;
    logic        Zero = 1'b0, lt = 1'b0, ltu = 1'b0;
    logic        imem_req, dmem_req, MemWrite, ALUSrc, RegWrite, PCEn, halted, illegal;
    logic [1:0]  ResultSrc, PCSrc;
    logic [2:0]  ImmSrc;
    logic [3:0]  ALUControl;
    logic [31:0] retire_count;

    mc_core_sequencer #(.HALT_ON_ILLEGAL(HALT_P)) dut (
        .clk(clk), .reset(reset), .Instr(Instr), .imem_req(imem_req), .imem_valid(imem_valid),
        .dmem_req(dmem_req), .dmem_ready(dmem_ready), .MemWrite(MemWrite),
        .Zero(Zero), .lt(lt), .ltu(ltu), .ResultSrc(ResultSrc), .PCSrc(PCSrc), .ALUSrc(ALUSrc),
        .RegWrite(RegWrite), .ImmSrc(ImmSrc), .ALUControl(ALUControl), .PCEn(PCEn),
        .retire_count(retire_count), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       imem_req;
        logic       dmem_req;
        logic       MemWrite;
        logic [1:0] ResultSrc;
        logic [1:0] PCSrc;
        logic       ALUSrc;
        logic       RegWrite;
        logic [2:0] ImmSrc;
        logic [3:0] ALUControl;
        logic       PCEn;
        logic       halted;
        logic       illegal;
    } ctl_t;

    int          checks = 0;
    int          failures = 0;
    int unsigned exp_rc = 0;
    ctl_t        tr_c[$];
    logic [31:0] tr_rc[$];

    // ALU code by funct3 for the non-alternate form (ADD, SLL, SLT, SLTU, XOR, SRL, OR, AND).
    localparam logic [3:0] ALU_BY_F3 [8] = '{4'h0, 4'h7, 4'h5, 4'h6, 4'h4, 4'h8, 4'h3, 4'h2};
    localparam logic [6:0] LEGAL_OPS [9] = '{7'h33, 7'h13, 7'h37, 7'h6f, 7'h67, 7'h63, 7'h03, 7'h23, 7'h0f};

    // nxt: 0 back to fetch, 1 data-memory phase, 2 halt
    function automatic ctl_t model_exec(input logic [31:0] w, input logic z, input logic l,
                                        input logic lu, output int nxt);
        ctl_t       e;
        logic [2:0] f3;
        logic [6:0] f7;
        logic       is_bad;
        logic       cond;
        e = '0; f3 = w[14:12]; f7 = w[31:25]; is_bad = 1'b0; cond = 1'b0; nxt = 0;
        case (w[6:0])
            7'h33: begin
                e.ALUControl = (f3 == 3'd0 && f7[5]) ? 4'h1 : (f3 == 3'd5 && f7[5]) ? 4'h9 : ALU_BY_F3[f3];
                e.RegWrite = 1'b1; e.PCEn = 1'b1;
            end
            7'h13: begin
                if (f3 == 3'd1) is_bad = (f7 != 7'h00);
                if (f3 == 3'd5) is_bad = (f7 != 7'h00) && (f7 != 7'h20);
                e.ALUSrc = 1'b1;
                e.ALUControl = (f3 == 3'd5 && f7[5]) ? 4'h9 : ALU_BY_F3[f3];
                e.RegWrite = 1'b1; e.PCEn = 1'b1;
            end
            7'h37: begin
                e.ImmSrc = 3'd4; e.ALUSrc = 1'b1; e.ALUControl = 4'hA; e.RegWrite = 1'b1; e.PCEn = 1'b1;
            end
            7'h6f: begin
                e.ImmSrc = 3'd3; e.ResultSrc = 2'd2; e.PCSrc = 2'd1; e.RegWrite = 1'b1; e.PCEn = 1'b1;
            end
            7'h67: begin
                is_bad = (f3 != 3'd0);
                e.ALUSrc = 1'b1; e.ResultSrc = 2'd2; e.PCSrc = 2'd2; e.RegWrite = 1'b1; e.PCEn = 1'b1;
            end
            7'h63: begin
                case (f3)
                    3'd0: cond = z;
                    3'd1: cond = !z;
                    3'd4: cond = l;
                    3'd5: cond = !l;
                    3'd6: cond = lu;
                    3'd7: cond = !lu;
                    default: is_bad = 1'b1;
                endcase
                e.ImmSrc = 3'd2; e.ALUControl = 4'h1; e.PCSrc = cond ? 2'd1 : 2'd0; e.PCEn = 1'b1;
            end
            7'h03: begin e.ALUSrc = 1'b1; nxt = 1; end
            7'h23: begin e.ImmSrc = 3'd1; e.ALUSrc = 1'b1; nxt = 1; end
            7'h0f: e.PCEn = 1'b1;
            7'h73: nxt = 2;
            default: is_bad = 1'b1;
        endcase
        if (is_bad) begin
            e = '0;
            if (HALT_P) nxt = 2;
            else begin e.PCEn = 1'b1; nxt = 0; end
        end
        return e;
    endfunction

    function automatic ctl_t model_mem(input logic store, input logic rdy);
        ctl_t m;
        m = '0;
        m.dmem_req = 1'b1; m.MemWrite = store; m.ALUSrc = 1'b1; m.ImmSrc = store ? 3'd1 : 3'd0;
        if (rdy) begin
            m.PCEn = 1'b1;
            if (!store) begin m.RegWrite = 1'b1; m.ResultSrc = 2'd1; end
        end
        return m;
    endfunction

    function automatic ctl_t sample();
        ctl_t s;
        s.imem_req = imem_req; s.dmem_req = dmem_req; s.MemWrite = MemWrite;
        s.ResultSrc = ResultSrc; s.PCSrc = PCSrc; s.ALUSrc = ALUSrc; s.RegWrite = RegWrite;
        s.ImmSrc = ImmSrc; s.ALUControl = ALUControl; s.PCEn = PCEn;
        s.halted = halted; s.illegal = illegal;
        return s;
    endfunction

    task automatic step(input logic v, input logic [31:0] ins, input logic rdy,
                        input logic z, input logic l, input logic lu);
        @(negedge clk);
        imem_valid = v; Instr = ins; dmem_ready = rdy; Zero = z; lt = l; ltu = lu;
        #1;
        tr_c.push_back(sample());
        tr_rc.push_back(retire_count);
    endtask

    task automatic run_instr(input logic [31:0] w, input int unsigned fd, input int unsigned md,
                             input logic z, input logic l, input logic lu);
        int nxt;
        tr_c.delete(); tr_rc.delete();
        for (int unsigned i = 0; i < fd; i++)
            step(1'b0, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'b1, w, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
        step(1'($urandom), $urandom, 1'($urandom), z, l, lu);
        void'(model_exec(w, z, l, lu, nxt));
        if (nxt == 1) begin
            for (int unsigned j = 0; j < md; j++)
                step(1'($urandom), $urandom, 1'b0, 1'($urandom), 1'($urandom), 1'($urandom));
            step(1'($urandom), $urandom, 1'b1, 1'($urandom), 1'($urandom), 1'($urandom));
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        imem_valid = 1'b0; dmem_ready = 1'b0; reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        exp_rc = 0;
    endtask

    task automatic test_reset();
        ctl_t zero_c;
        zero_c = '0;
        imem_valid = 1'b1; dmem_ready = 1'b1; Instr = 32'h00500093; Zero = 1'b1;
        @(negedge clk); #1;
        checks++;
        if (sample() !== zero_c || retire_count !== 32'd0) begin
            failures++; $display("FAIL reset_outputs got=%h rc=%h exp=0", sample(), retire_count);
        end
        @(negedge clk);
        reset = 1'b1; imem_valid = 1'b0;
        #1;
        checks++;
        if (imem_req !== 1'b1) begin failures++; $display("FAIL reset_release_req got=%b exp=1", imem_req); end
        exp_rc = 0;
    endtask

    task automatic test_addi();
        ctl_t e;
        int   nxt;
        run_instr(32'h00500093, 2, 0, 1'b0, 1'b0, 1'b0);
        e = model_exec(32'h00500093, 1'b0, 1'b0, 1'b0, nxt);
        for (int k = 0; k < 3; k++) begin
            checks++;
            if (tr_c[k].imem_req !== 1'b1) begin failures++; $display("FAIL addi_fetch_req[%0d] got=%b exp=1", k, tr_c[k].imem_req); end
        end
        checks++;
        if (tr_c[3] !== e) begin failures++; $display("FAIL addi_exec got=%h exp=%h", tr_c[3], e); end
        checks++;
        if ({tr_c[3].ALUSrc, tr_c[3].ImmSrc, tr_c[3].ALUControl, tr_c[3].ResultSrc, tr_c[3].RegWrite, tr_c[3].PCEn} !== 12'b1_000_0000_00_1_1) begin
            failures++; $display("FAIL addi_fields got=%h", tr_c[3]);
        end
        exp_rc++;
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_c[4].imem_req !== 1'b1 || tr_c[4].PCEn !== 1'b0 || tr_c[4].RegWrite !== 1'b0 || tr_rc[4] !== 32'(exp_rc)) begin
            failures++; $display("FAIL addi_after got=%h rc=%0d exp_rc=%0d", tr_c[4], tr_rc[4], exp_rc);
        end
    endtask

    task automatic test_branch();
        ctl_t e;
        int   nxt;
        for (int zi = 1; zi >= 0; zi--) begin
            run_instr(32'h00000463, 0, 0, 1'(zi), 1'($urandom), 1'($urandom));
            e = model_exec(32'h00000463, 1'(zi), lt, ltu, nxt);
            checks++;
            if (tr_c[1] !== e) begin failures++; $display("FAIL beq_exec z=%0d got=%h exp=%h", zi, tr_c[1], e); end
            checks++;
            if (tr_c[1].PCSrc !== ((zi == 1) ? 2'b01 : 2'b00) || tr_c[1].ALUControl !== 4'b0001 ||
                tr_c[1].RegWrite !== 1'b0 || tr_c[1].PCEn !== 1'b1) begin
                failures++; $display("FAIL beq_fields z=%0d got=%h", zi, tr_c[1]);
            end
            exp_rc++;
            step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
            checks++;
            if (tr_rc[2] !== 32'(exp_rc)) begin failures++; $display("FAIL beq_retire got=%0d exp=%0d", tr_rc[2], exp_rc); end
        end
    endtask

    task automatic test_load();
        run_instr(32'h00402103, 0, 3, 1'b0, 1'b0, 1'b0);
        for (int k = 2; k <= 5; k++) begin
            checks++;
            if (tr_c[k].dmem_req !== 1'b1 || tr_c[k].MemWrite !== 1'b0 ||
                tr_c[k].RegWrite !== (k == 5) || tr_c[k].PCEn !== (k == 5)) begin
                failures++; $display("FAIL lw_mem[%0d] got=%h", k, tr_c[k]);
            end
        end
        checks++;
        if (tr_c[5].ResultSrc !== 2'b01 || tr_c[5].PCSrc !== 2'b00) begin
            failures++; $display("FAIL lw_ready got=%h exp ResultSrc=01 PCSrc=00", tr_c[5]);
        end
        exp_rc++;
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_c[6].imem_req !== 1'b1 || tr_c[6].dmem_req !== 1'b0 || tr_rc[6] !== 32'(exp_rc)) begin
            failures++; $display("FAIL lw_after got=%h rc=%0d exp_rc=%0d", tr_c[6], tr_rc[6], exp_rc);
        end
    endtask

    task automatic test_store();
        run_instr(32'h00202423, 0, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_c[2].MemWrite !== 1'b1 || tr_c[2].dmem_req !== 1'b1 || tr_c[2].RegWrite !== 1'b0 ||
            tr_c[2].PCEn !== 1'b1 || tr_c[2].ImmSrc !== 3'b001) begin
            failures++; $display("FAIL sw_mem got=%h", tr_c[2]);
        end
        exp_rc++;
        step(1'b0, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_c[3].imem_req !== 1'b1 || tr_c[3].dmem_req !== 1'b0 || tr_rc[3] !== 32'(exp_rc)) begin
            failures++; $display("FAIL sw_after got=%h rc=%0d exp_rc=%0d", tr_c[3], tr_rc[3], exp_rc);
        end
    endtask

    task automatic test_random();
        logic [31:0] w;
        logic [6:0]  op;
        int unsigned fd, md;
        logic        z, l, lu;
        int          nxt;
        ctl_t        e, f;
        do_reset();
        f = '0; f.imem_req = 1'b1;
        for (int n = 0; n < 120; n++) begin
            w = $urandom;
            op = LEGAL_OPS[$urandom_range(0, 8)];
            w[6:0] = op;
            if (op == 7'h67) w[14:12] = 3'd0;
            if (op == 7'h63 && w[14:13] == 2'b01) w[13] = 1'b0;
            if (op == 7'h13 && w[14:12] == 3'd1) w[31:25] = 7'h00;
            if (op == 7'h13 && w[14:12] == 3'd5) w[31:25] = ($urandom_range(0, 1) == 1) ? 7'h20 : 7'h00;
            fd = $urandom_range(0, 3); md = $urandom_range(0, 3);
            z = 1'($urandom); l = 1'($urandom); lu = 1'($urandom);
            e = model_exec(w, z, l, lu, nxt);
            run_instr(w, fd, md, z, l, lu);
            checks++;
            if (tr_rc[0] !== 32'(exp_rc)) begin failures++; $display("FAIL rand_retire[%0d] got=%0d exp=%0d", n, tr_rc[0], exp_rc); end
            for (int unsigned k = 0; k <= fd; k++) begin
                checks++;
                if (tr_c[k] !== f) begin failures++; $display("FAIL rand_fetch[%0d] got=%h exp=%h", n, tr_c[k], f); end
            end
            checks++;
            if (tr_c[fd+1] !== e) begin failures++; $display("FAIL rand_exec[%0d] w=%h got=%h exp=%h", n, w, tr_c[fd+1], e); end
            if (e.PCEn) exp_rc++;
            if (nxt == 1) begin
                checks++;
                if (tr_c.size() != int'(fd + md + 3)) begin failures++; $display("FAIL rand_len[%0d] got=%0d exp=%0d", n, tr_c.size(), fd + md + 3); end
                for (int unsigned k = 0; k <= md; k++) begin
                    checks++;
                    if (tr_c[fd+2+k] !== model_mem(op == 7'h23, k == md)) begin
                        failures++; $display("FAIL rand_mem[%0d.%0d] got=%h exp=%h", n, k, tr_c[fd+2+k], model_mem(op == 7'h23, k == md));
                    end
                end
                exp_rc++;
            end
        end
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_rc[tr_rc.size()-1] !== 32'(exp_rc)) begin
            failures++; $display("FAIL rand_final_retire got=%0d exp=%0d", tr_rc[tr_rc.size()-1], exp_rc);
        end
    endtask

    task automatic test_reset_mid_mem();
        tr_c.delete(); tr_rc.delete();
        step(1'b1, 32'h00402103, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        step(1'b0, $urandom, 1'b0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_c[3].dmem_req !== 1'b1 || tr_rc[3] !== 32'(exp_rc)) begin
            failures++; $display("FAIL rst_mem_wait got=%h rc=%0d exp_rc=%0d", tr_c[3], tr_rc[3], exp_rc);
        end
        #2 reset = 1'b0; dmem_ready = 1'b1;
        #1;
        checks++;
        if (dmem_req !== 1'b0 || imem_req !== 1'b0 || PCEn !== 1'b0 || retire_count !== 32'd0) begin
            failures++; $display("FAIL rst_mem_abort got=%h rc=%0d exp=0", sample(), retire_count);
        end
        @(negedge clk);
        reset = 1'b1; dmem_ready = 1'b0; exp_rc = 0;
        #1;
        checks++;
        if (imem_req !== 1'b1 || dmem_req !== 1'b0 || retire_count !== 32'd0) begin
            failures++; $display("FAIL rst_mem_release got=%h rc=%0d", sample(), retire_count);
        end
    endtask

    task automatic test_ecall();
        run_instr(32'h00000073, 1, 0, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_c[2].PCEn !== 1'b0 || tr_c[2].RegWrite !== 1'b0) begin failures++; $display("FAIL ecall_exec got=%h", tr_c[2]); end
        step(1'b1, $urandom, 1'b1, 1'b0, 1'b0, 1'b0);
        checks++;
        if (tr_c[3].halted !== 1'b1 || tr_c[3].illegal !== 1'b0 || tr_c[3].imem_req !== 1'b0 || tr_rc[3] !== 32'(exp_rc)) begin
            failures++; $display("FAIL ecall_halt got=%h rc=%0d exp_rc=%0d", tr_c[3], tr_rc[3], exp_rc);
        end
    endtask

    task automatic test_illegal();
        ctl_t e, h;
        int   nxt;
        do_reset();
        run_instr(32'h00500093, 0, 0, 1'b0, 1'b0, 1'b0);
        exp_rc++;
        run_instr(32'hFFFFFFFF, 1, 0, 1'b1, 1'b1, 1'b1);
        e = model_exec(32'hFFFFFFFF, 1'b1, 1'b1, 1'b1, nxt);
        checks++;
        if (tr_c[2] !== e) begin failures++; $display("FAIL illegal_exec got=%h exp=%h", tr_c[2], e); end
        h = '0; h.halted = 1'b1; h.illegal = 1'b1;
        for (int k = 0; k < 20; k++) begin
            step(1'b1, $urandom, 1'($urandom), 1'($urandom), 1'($urandom), 1'($urandom));
            checks++;
            if (tr_c[tr_c.size()-1] !== h || tr_rc[tr_rc.size()-1] !== 32'(exp_rc)) begin
                failures++; $display("FAIL illegal_halt[%0d] got=%h rc=%0d exp=%h rc=%0d", k, tr_c[tr_c.size()-1], tr_rc[tr_rc.size()-1], h, exp_rc);
            end
        end
        do_reset();
        #1;
        checks++;
        if (illegal !== 1'b0 || halted !== 1'b0 || imem_req !== 1'b1) begin
            failures++; $display("FAIL illegal_cleared got=%h", sample());
        end
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_addi();
        test_branch();
        test_load();
        test_store();
        test_random();
        test_reset_mid_mem();
        test_ecall();
        test_illegal();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
